// File: rtl/prng_pkg.sv
// Shared types and helpers for the PRNG request sequencer.
//   state_e   : sequencer FSM states
//   DATA_W/CTRL_W and tap masks for the data and control LFSRs
//   rr_pick   : round-robin winner search starting at a pointer (NREQ <= 8)
package prng_pkg;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;

  localparam int DATA_W = 16;
  localparam int CTRL_W = 8;

  // Feedback taps: data bits 15,14,12,3; control bits 7,5,4,3 (XNOR feedback)
  localparam logic [DATA_W-1:0] DATA_TAPS = 16'hD008;
  localparam logic [CTRL_W-1:0] CTRL_TAPS = 8'hB8;

  // First set request at or after ptr, wrapping modulo nreq.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int nreq);
    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = 3'((int'(ptr) + i) % nreq);
      if (i < nreq && !found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/prng_req_sequencer_if.sv
// Requester-side bus of the PRNG sequencer.
//   ena, req       : block enable and level requests (requester -> sequencer)
//   gnt, rnd_valid : one-hot grant and byte-valid pulse (sequencer -> requester)
//   rnd_data, busy : random byte and activity flag
//   seed_load/seed : present only when PRNG_SEED_EN is defined
interface prng_req_sequencer_if #(parameter int NREQ = 4);
  logic            ena;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [7:0]      rnd_data;
  logic            busy;
`ifdef PRNG_SEED_EN
  logic            seed_load;
  logic [15:0]     seed;

  modport master (output ena, req, seed_load, seed,
                  input  gnt, rnd_valid, rnd_data, busy);
  modport slave  (input  ena, req, seed_load, seed,
                  output gnt, rnd_valid, rnd_data, busy);
`else
  modport master (output ena, req,
                  input  gnt, rnd_valid, rnd_data, busy);
  modport slave  (input  ena, req,
                  output gnt, rnd_valid, rnd_data, busy);
`endif
endinterface

// File: rtl/prng_core.sv
// PRNG datapath: 16-bit data LFSR, 8-bit control LFSR, 16->8 select mux.
//   clk, reset   : clock, synchronous active-high reset (both LFSRs -> 0)
//   i_step_d     : step the data LFSR this cycle
//   i_step_c     : step the control LFSR this cycle
//   i_load       : load data LFSR from i_seed (all-ones coerced to FFFE)
//   o_byte_nxt   : mux of the post-update LFSR values, ready to register
module prng_core
  import prng_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_step_d,
  input  logic              i_step_c,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_seed,
  output logic [7:0]        o_byte_nxt
);

  logic [DATA_W-1:0] r_d, w_d_nxt, w_seed_fix;
  logic [CTRL_W-1:0] r_c, w_c_nxt;

  // All-ones is the XNOR lock-up state; never allow it in via the seed.
  assign w_seed_fix = (i_seed == '1) ? 16'hFFFE : i_seed;

  always_comb begin
    w_d_nxt = r_d;
    if (i_load)        w_d_nxt = w_seed_fix;
    else if (i_step_d) w_d_nxt = {r_d[DATA_W-2:0], ~(^(r_d & DATA_TAPS))};
    w_c_nxt = r_c;
    if (i_step_c)      w_c_nxt = {r_c[CTRL_W-2:0], ~(^(r_c & CTRL_TAPS))};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= '0;
      r_c <= '0;
    end else begin
      r_d <= w_d_nxt;
      r_c <= w_c_nxt;
    end
  end

  always_comb begin
    o_byte_nxt = '0;
    for (int j = 0; j < 8; j++)
      o_byte_nxt[j] = w_c_nxt[j] ? w_d_nxt[2*j+1] : w_d_nxt[2*j];
  end

endmodule

// File: rtl/prng_req_sequencer.sv
// Shares one PRNG datapath between NREQ requesters with round-robin
// arbitration. Per grant the data LFSR steps once on the accepting IDLE
// cycle and once per STEP cycle; the byte is registered on the last STEP
// cycle so gnt/rnd_valid/rnd_data are visible during DONE.
//   clk, reset : sole clock, synchronous active-high reset
//   bus        : prng_req_sequencer_if.slave (ena, req, gnt, rnd_valid,
//                rnd_data, busy; seed_load/seed with PRNG_SEED_EN)
// Optional feature macro: PRNG_SEED_EN (seed loading in IDLE).
module prng_req_sequencer
  import prng_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int STEPS    = 8,
  parameter int CTRL_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  prng_req_sequencer_if.slave   bus
);

  localparam logic [7:0] STEP_LAST = 8'(STEPS - 1);
  localparam logic [3:0] DIV_LAST  = 4'(CTRL_DIV - 1);

  state_e          r_state, w_state_nxt;
  logic [2:0]      r_winner, r_ptr;
  logic [7:0]      r_step;
  logic [3:0]      r_div;
  logic [NREQ-1:0] r_gnt;
  logic            r_valid;
  logic [7:0]      r_data;
  logic            w_step_d, w_step_c, w_start, w_last, w_load, w_seed_ld;
  logic [15:0]     w_seed;
  logic [7:0]      w_byte_nxt;

`ifdef PRNG_SEED_EN
  assign w_seed_ld = bus.seed_load;
  assign w_seed    = bus.seed;
`else
  assign w_seed_ld = 1'b0;
  assign w_seed    = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_step_d    = 1'b0;
    w_start     = 1'b0;
    w_last      = 1'b0;
    w_load      = 1'b0;
    if (!bus.ena) begin
      w_state_nxt = IDLE;       // abort: everything else holds
    end else begin
      case (r_state)
        IDLE: begin
          if (w_seed_ld) begin
            w_load = 1'b1;      // seed wins; grant can start next cycle
          end else if (|bus.req) begin
            w_start     = 1'b1;
            w_step_d    = 1'b1;
            w_state_nxt = STEP;
          end
        end
        STEP: begin
          w_step_d = 1'b1;
          if (r_step == STEP_LAST) begin
            w_last      = 1'b1;
            w_state_nxt = DONE;
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_step_c = w_step_d && (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_winner <= '0;
      r_ptr    <= '0;
      r_step   <= '0;
      r_div    <= '0;
      r_gnt    <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Divider runs free across grants.
      if (w_step_d) r_div <= w_step_c ? 4'd0 : r_div + 4'd1;
      if (w_start) begin
        r_winner <= rr_pick(8'(bus.req), r_ptr, NREQ);
        r_step   <= '0;
      end else if (w_step_d) begin
        r_step <= r_step + 8'd1;
      end
      r_valid <= w_last;
      r_gnt   <= w_last ? (NREQ'(1) << r_winner) : '0;
      if (w_last) r_data <= w_byte_nxt;
      if (bus.ena && r_state == DONE)
        r_ptr <= (r_winner == 3'(NREQ - 1)) ? 3'd0 : r_winner + 3'd1;
    end
  end

  prng_core u_core (
    .clk        (clk),
    .reset      (reset),
    .i_step_d   (w_step_d),
    .i_step_c   (w_step_c),
    .i_load     (w_load),
    .i_seed     (w_seed),
    .o_byte_nxt (w_byte_nxt)
  );

  assign bus.gnt       = r_gnt;
  assign bus.rnd_valid = r_valid;
  assign bus.rnd_data  = r_data;
  assign bus.busy      = (r_state == STEP) || (r_state == DONE);

endmodule

// File: tb/tb_prng_req_sequencer.sv
module tb_prng_req_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   n;

  // Reference PRNG state, advanced by the bench as the grants happen.
  logic [15:0] m_d;
  logic [7:0]  m_c;
  int          m_div;
  logic [7:0]  exp_b;

  always #5 clk = ~clk;

  prng_req_sequencer_if #(.NREQ(4)) bus_if ();

  prng_req_sequencer #(.NREQ(4), .STEPS(8), .CTRL_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles until rnd_valid is seen, capped so a dead DUT cannot hang the run.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus_if.rnd_valid && cnt < 40);
  endtask

  task automatic m_reset();
    m_d = 16'h0; m_c = 8'h0; m_div = 0;
  endtask

  task automatic m_step();
    m_d = {m_d[14:0], ~(m_d[15] ^ m_d[14] ^ m_d[12] ^ m_d[3])};
    if (m_div == 3) begin
      m_c   = {m_c[6:0], ~(m_c[7] ^ m_c[5] ^ m_c[4] ^ m_c[3])};
      m_div = 0;
    end else begin
      m_div++;
    end
  endtask

  function automatic logic [7:0] m_mux(input logic [15:0] d, input logic [7:0] c);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = c[j] ? d[2*j+1] : d[2*j];
    return r;
  endfunction

  // A full grant: one step on acceptance plus eight in STEP.
  task automatic m_grant(output logic [7:0] b);
    for (int k = 0; k < 9; k++) m_step();
    b = m_mux(m_d, m_c);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.ena = 1'b1;
    bus_if.req = 4'b0000;
`ifdef PRNG_SEED_EN
    bus_if.seed_load = 1'b0;
    bus_if.seed = 16'h0;
`endif
    m_reset();
    tick(); tick();
    chk("rst_gnt",   32'(bus_if.gnt), 32'h0);
    chk("rst_valid", 32'(bus_if.rnd_valid), 32'h0);
    chk("rst_data",  32'(bus_if.rnd_data), 32'h0);
    chk("rst_busy",  32'(bus_if.busy), 32'h0);

    // 1: single request, defaults
    reset = 1'b0;
    bus_if.req = 4'b0001;
    tick();
    bus_if.req = 4'b0000;
    wait_valid(n);
    chk("t1_latency", 32'(n + 1), 32'd9);
    chk("t1_gnt",  32'(bus_if.gnt), 32'h1);
    chk("t1_data", 32'(bus_if.rnd_data), 32'h18);
    chk("t1_busy", 32'(bus_if.busy), 32'h1);
    m_grant(exp_b);
    tick();
    chk("t1_pulse", 32'(bus_if.rnd_valid), 32'h0);
    chk("t1_hold",  32'(bus_if.rnd_data), 32'h18);
    tick(); tick();
    chk("t1_idle_busy", 32'(bus_if.busy), 32'h0);

    // 2: two requesters held, pointer at 1
    bus_if.req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      wait_valid(n);
      chk("t2_gap", 32'(n), (g == 0) ? 32'd9 : 32'd10);
      chk("t2_gnt", 32'(bus_if.gnt), (g % 2 == 0) ? 32'h2 : 32'h8);
      chk("t2_onehot", 32'($countones(bus_if.gnt)), 32'd1);
      m_grant(exp_b);
      chk("t2_data", 32'(bus_if.rnd_data), 32'(exp_b));
    end
    bus_if.req = 4'b0000;
    tick();

    // 3: all four held, pointer at 0
    bus_if.req = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      wait_valid(n);
      chk("t3_gnt", 32'(bus_if.gnt), 32'(1 << (g % 4)));
      m_grant(exp_b);
      chk("t3_data", 32'(bus_if.rnd_data), 32'(exp_b));
    end
    bus_if.req = 4'b0000;
    tick();

    // 4: ena dropped three cycles into STEP
    bus_if.req = 4'b0001;
    tick(); m_step();
    bus_if.req = 4'b0000;
    tick(); tick(); tick();
    m_step(); m_step(); m_step();
    bus_if.ena = 1'b0;
    tick();
    chk("t4_busy",  32'(bus_if.busy), 32'h0);
    chk("t4_valid", 32'(bus_if.rnd_valid), 32'h0);
    bus_if.req = 4'b0100;
    tick(); tick();
    chk("t4_ena_low_idle", 32'(bus_if.busy), 32'h0);
    chk("t4_ena_low_nov",  32'(bus_if.rnd_valid), 32'h0);
    bus_if.ena = 1'b1;
    bus_if.req = 4'b0001;
    tick();
    bus_if.req = 4'b0000;
    wait_valid(n);
    chk("t4_latency", 32'(n + 1), 32'd9);
    chk("t4_gnt", 32'(bus_if.gnt), 32'h1);
    m_grant(exp_b);
    chk("t4_data", 32'(bus_if.rnd_data), 32'(exp_b));
    tick();

    // 5: reset mid-STEP
    bus_if.req = 4'b0010;
    tick();
    bus_if.req = 4'b0000;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("t5_busy", 32'(bus_if.busy), 32'h0);
    chk("t5_data", 32'(bus_if.rnd_data), 32'h0);
    chk("t5_gnt",  32'(bus_if.gnt), 32'h0);
    reset = 1'b0;
    m_reset();
    bus_if.req = 4'b0001;
    tick();
    bus_if.req = 4'b0000;
    wait_valid(n);
    chk("t5_latency", 32'(n + 1), 32'd9);
    chk("t5_gnt",  32'(bus_if.gnt), 32'h1);
    chk("t5_byte", 32'(bus_if.rnd_data), 32'h18);
    m_grant(exp_b);
    tick();

`ifdef PRNG_SEED_EN
    // 6: seed loading
    bus_if.seed = 16'hFFFF;
    bus_if.seed_load = 1'b1;
    tick();
    bus_if.seed_load = 1'b0;
    m_d = 16'hFFFE;
    chk("t6_load_idle", 32'(bus_if.busy), 32'h0);
    bus_if.req = 4'b0001;
    tick();
    bus_if.req = 4'b0000;
    wait_valid(n);
    m_grant(exp_b);
    chk("t6_coerce", 32'(bus_if.rnd_data), 32'(exp_b));
    tick();
    bus_if.req = 4'b0010;
    tick();
    bus_if.req = 4'b0000;
    bus_if.seed = 16'h1234;
    bus_if.seed_load = 1'b1;
    tick();
    bus_if.seed_load = 1'b0;
    wait_valid(n);
    m_grant(exp_b);
    chk("t6_ignore_step", 32'(bus_if.rnd_data), 32'(exp_b));
    chk("t6_gnt", 32'(bus_if.gnt), 32'h2);
    tick();
    bus_if.seed = 16'hABCD;
    bus_if.seed_load = 1'b1;
    bus_if.req = 4'b0001;
    tick();
    bus_if.seed_load = 1'b0;
    m_d = 16'hABCD;
    chk("t6_load_first", 32'(bus_if.busy), 32'h0);
    tick();
    bus_if.req = 4'b0000;
    chk("t6_grant_next", 32'(bus_if.busy), 32'h1);
    wait_valid(n);
    chk("t6_latency", 32'(n + 2), 32'd10);
    m_grant(exp_b);
    chk("t6_data", 32'(bus_if.rnd_data), 32'(exp_b));
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
